set_assoc_cache: RTL and testbench
==================================

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameter NUM_SETS, default 16, number of sets (power of two, >=2).
REQ-002 SHALL have parameter NUM_WAYS, default 2, associativity (power of two, 1..8).
REQ-003 SHALL have parameter BLOCK_WORDS, default 4, 32-bit words per block (power of two, >=2).
REQ-004 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have cpu_req  input  1  request valid; cpu_we, cpu_addr and cpu_wdata are held stable until cpu_ack.
REQ-007 SHALL have cpu_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have cpu_addr  input  30  word address [31:2].
REQ-009 SHALL have cpu_wdata  input  32  store data.
REQ-010 SHALL have cpu_rdata  output  32  load data, valid while cpu_ack=1.
REQ-011 SHALL have cpu_ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have mem_valid  output  1  backing-memory word transfer request.
REQ-013 SHALL have mem_we  output  1  1 = write-back word, 0 = refill read.
REQ-014 SHALL have mem_addr  output  30  word address of the transfer.
REQ-015 SHALL have mem_wdata  output  32  write-back data.
REQ-016 SHALL have mem_ready  input  1  transfer completes in any cycle with mem_valid=1 and mem_ready=1.
REQ-017 SHALL have mem_rdata  input  32  refill data, sampled in the completing cycle.
REQ-018 SHALL have hit_count and miss_count  output  32 each  statistics counters.

Function
REQ-019 Address split SHALL be offset=addr[OB-1:0], index=addr[OB+IB-1:OB], tag=the remaining upper bits, where OB=log2(BLOCK_WORDS) and IB=log2(NUM_SETS).
REQ-020 Hit SHALL be defined as a valid way in the indexed set whose tag equals the address tag. At most one way SHALL ever match.
REQ-021 FSM states SHALL be IDLE, WRITEBACK, REFILL, RESPOND.
REQ-022 IDLE with cpu_req and hit:
- cpu_ack SHALL assert combinationally in the same cycle (zero-wait hit).
- Store: SHALL write the word at the clock edge and set the dirty bit of that way.
- SHALL update replacement state.
REQ-023 IDLE with cpu_req and miss: SHALL latch the victim way and go to WRITEBACK if the victim is valid and dirty, otherwise to REFILL.
REQ-024 WRITEBACK SHALL issue BLOCK_WORDS writes of the victim block at victim-tag addresses, offsets 0 upward. It SHALL go to REFILL after the last transfer completes.
REQ-025 REFILL SHALL issue BLOCK_WORDS reads, offsets 0 upward, writing each word into the victim way.
- After the last transfer completes: set valid, write the tag, clear dirty, go to RESPOND.
REQ-026 RESPOND SHALL complete the request as a hit (including the store write and dirty set), assert cpu_ack for one cycle, and return to IDLE.
REQ-027 mem_valid SHALL stay asserted with mem_addr/mem_we/mem_wdata stable until mem_ready. Wait states of any length SHALL be tolerated.
REQ-028 Victim selection SHALL pick the lowest-numbered invalid way; if all ways are valid, it SHALL pick the way given by the per-set round-robin pointer.
- The pointer SHALL advance (modulo NUM_WAYS) only when a refill completes in that set.
REQ-029 cpu_req deasserted in IDLE SHALL produce no state change. cpu_ack SHALL never assert outside IDLE-hit and RESPOND.
REQ-030 Miss latency without write-back SHALL be BLOCK_WORDS completed transfers plus 1 cycle. A dirty victim SHALL add a further BLOCK_WORDS transfers.

Reset
REQ-031 rst_n low SHALL immediately:
- clear all valid and dirty bits, round-robin pointers and counters;
- force IDLE and drive mem_valid=0, cpu_ack=0.
Data and tag arrays are not reset.
REQ-032 Reset asserted mid-WRITEBACK/REFILL SHALL abort the transfer. The partially refilled way SHALL remain invalid.

Configuration
REQ-033 Macro CACHE_STATS_EN, when defined, SHALL enable the statistics counters:
- hit_count increments on each IDLE-hit ack; miss_count increments on each IDLE miss detection.
- Both counters saturate at 0xFFFFFFFF.
REQ-034 Without CACHE_STATS_EN, hit_count and miss_count SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-035 Package cache_pkg SHALL hold the FSM state enum and the derived-width helper constants/functions.
REQ-036 Sub-module cache_victim_sel SHALL implement the combinational victim choice from valid bits and the pointer.

Verification (NUM_SETS=16, NUM_WAYS=2, BLOCK_WORDS=4)
REQ-037 Cold load 0x10 with memory word n = n+0x100 -> 4 reads at 0x10..0x13, ack returns 0x110; an immediate reload of 0x12 acks in the same cycle with 0x112.
REQ-038 Store 0xDEADBEEF to 0x11 (hit), then loads of 0x50 and 0x90 (same set 4) -> the 0x90 miss evicts way 0, writes back 0x10..0x13 with 0xDEADBEEF at 0x11, then refills 0x90..0x93.
REQ-039 mem_ready held low 5 cycles on each transfer -> mem_addr stable throughout, and the correct data is returned.
REQ-040 rst_n pulsed low after the 2nd refill transfer -> mem_valid=0 at once, and the next load of the same address re-misses.
REQ-041 With CACHE_STATS_EN, 3 hits and 2 misses -> hit_count=3 and miss_count=2; without the macro, both read 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache.
package cache_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 30;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2,
    ST_RESPOND   = 2'd3
  } state_t;

  // One backing-memory word transfer
  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  // Index width that stays at least one bit wide for single-entry ranges
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tag width left over after the index and word-offset fields
  function automatic int unsigned tag_bits(input int unsigned sets, input int unsigned words);
    return ADDR_W - $clog2(sets) - $clog2(words);
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim choice: lowest-numbered invalid way, else the round-robin pointer.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 2,
  localparam int unsigned WW = idx_bits(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [WW-1:0]       ptr,
  output logic [WW-1:0]       victim_way_c
);

  // Scan from the top so the lowest invalid way wins
  always_comb begin
    victim_way_c = ptr;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid[i]) victim_way_c = WW'(i);
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate set-associative cache with zero-wait hits.
// Optional statistics counters are enabled by defining CACHE_STATS_EN.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = 16,
  parameter int unsigned NUM_WAYS    = 2,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [29:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned OB = $clog2(BLOCK_WORDS);
  localparam int unsigned IB = $clog2(NUM_SETS);
  localparam int unsigned TW = tag_bits(NUM_SETS, BLOCK_WORDS);
  localparam int unsigned WW = idx_bits(NUM_WAYS);
  localparam logic [OB-1:0] LAST_BEAT = OB'(BLOCK_WORDS - 1);
  localparam logic [WW-1:0] LAST_WAY  = WW'(NUM_WAYS - 1);

  // Address fields of the current request (held stable until ack)
  logic [TW-1:0] tag;
  logic [IB-1:0] idx;
  logic [OB-1:0] off;

  assign off = cpu_addr[OB-1:0];
  assign idx = cpu_addr[OB+IB-1:OB];
  assign tag = cpu_addr[ADDR_W-1:OB+IB];

  // Storage: data and tags are not reset, status bits are
  logic [WORD_W-1:0]   data_q  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic [TW-1:0]       tag_q   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [WW-1:0]       rr_q    [NUM_SETS];

  state_t        state_q, state_d;
  logic [WW-1:0] victim_q, victim_d;
  logic [OB-1:0] beat_q, beat_d;

  logic [NUM_WAYS-1:0] match;
  logic                hit;
  logic [WW-1:0]       hit_way;
  logic [WW-1:0]       vsel_way;

  logic              data_we;
  logic [WW-1:0]     data_way;
  logic [OB-1:0]     data_off;
  logic [WORD_W-1:0] data_wdata;
  logic              mark_dirty;
  logic              refill_done;
  logic [WW-1:0]     rd_way;
  mem_req_t          mem_req;

  // Tag compare across the indexed set
  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      match[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
      if (match[w]) hit_way = WW'(w);
    end
  end

  assign hit = |match;

  cache_victim_sel #(.NUM_WAYS(NUM_WAYS)) u_victim_sel (
    .valid        (valid_q[idx]),
    .ptr          (rr_q[idx]),
    .victim_way_c (vsel_way)
  );

  // Next-state, array write controls and memory request
  always_comb begin
    state_d        = state_q;
    victim_d       = victim_q;
    beat_d         = beat_q;
    cpu_ack        = 1'b0;
    data_we        = 1'b0;
    data_way       = hit_way;
    data_off       = off;
    data_wdata     = cpu_wdata;
    mark_dirty     = 1'b0;
    refill_done    = 1'b0;
    rd_way         = hit_way;
    mem_req.valid  = 1'b0;
    mem_req.we     = 1'b0;
    mem_req.addr   = {tag_q[idx][victim_q], idx, beat_q};
    mem_req.wdata  = data_q[idx][victim_q][beat_q];

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            cpu_ack = 1'b1;
            if (cpu_we) begin
              data_we    = 1'b1;
              mark_dirty = 1'b1;
            end
          end else begin
            victim_d = vsel_way;
            beat_d   = '0;
            state_d  = (valid_q[idx][vsel_way] && dirty_q[idx][vsel_way]) ?
                       ST_WRITEBACK : ST_REFILL;
          end
        end
      end
      ST_WRITEBACK: begin
        mem_req.valid = 1'b1;
        mem_req.we    = 1'b1;
        if (mem_ready) begin
          beat_d = beat_q + OB'(1);
          if (beat_q == LAST_BEAT) state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        mem_req.valid = 1'b1;
        mem_req.addr  = {tag, idx, beat_q};
        if (mem_ready) begin
          data_we    = 1'b1;
          data_way   = victim_q;
          data_off   = beat_q;
          data_wdata = mem_rdata;
          beat_d     = beat_q + OB'(1);
          if (beat_q == LAST_BEAT) begin
            refill_done = 1'b1;
            state_d     = ST_RESPOND;
          end
        end
      end
      ST_RESPOND: begin
        cpu_ack  = 1'b1;
        rd_way   = victim_q;
        data_way = victim_q;
        if (cpu_we) begin
          data_we    = 1'b1;
          mark_dirty = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_valid = mem_req.valid;
  assign mem_we    = mem_req.we;
  assign mem_addr  = mem_req.addr;
  assign mem_wdata = mem_req.wdata;
  assign cpu_rdata = data_q[idx][rd_way][off];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      victim_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      beat_q   <= beat_d;
    end
  end

  // Valid, dirty and round-robin pointer per set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (refill_done) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
        rr_q[idx]              <= (rr_q[idx] == LAST_WAY) ? '0 : rr_q[idx] + WW'(1);
      end
      if (mark_dirty) dirty_q[idx][data_way] <= 1'b1;
    end
  end

  // Tag and data arrays
  always_ff @(posedge clk) begin
    if (refill_done) tag_q[idx][victim_q] <= tag;
    if (data_we) data_q[idx][data_way][data_off] <= data_wdata;
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_q, miss_q;
  logic        hit_evt, miss_evt;

  assign hit_evt  = (state_q == ST_IDLE) && cpu_req && hit;
  assign miss_evt = (state_q == ST_IDLE) && cpu_req && !hit;

  // Saturating hit/miss counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_evt && (hit_q != '1))   hit_q  <= hit_q + 32'd1;
      if (miss_evt && (miss_q != '1)) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed self-checking bench for set_assoc_cache (16 sets, 2 ways, 4 words).
module tb_set_assoc_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        mem_valid, mem_we, mem_ready;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] hit_count, miss_count;

`ifdef CACHE_STATS_EN
  localparam logic [31:0] EXP_HITS   = 32'd3;
  localparam logic [31:0] EXP_MISSES = 32'd2;
`else
  localparam logic [31:0] EXP_HITS   = 32'd0;
  localparam logic [31:0] EXP_MISSES = 32'd0;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  // Backing memory: unwritten word n reads as n + 0x100
  logic [31:0]  bmem [256];
  logic [255:0] wr_mask = '0;
  int           wait_cfg = 0;
  int           wcnt = 0;
  int           unstable_cnt = 0;
  logic [29:0]  prev_addr = '0;
  logic         prev_pend = 1'b0;
  logic [29:0]  log_addr [$];
  logic         log_we [$];
  logic [31:0]  log_data [$];

  logic [31:0] exp_wb [4] = '{32'h0000_0110, 32'hDEAD_BEEF, 32'h0000_0112, 32'h0000_0113};

  set_assoc_cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  assign mem_ready = mem_valid && (wcnt >= wait_cfg);
  assign mem_rdata = wr_mask[mem_addr[7:0]] ? bmem[mem_addr[7:0]] : ({2'b00, mem_addr} + 32'h100);

  // Memory responder: wait states, transfer log, address stability watch
  always @(posedge clk) begin
    if (!rst_n) begin
      wcnt <= 0;
    end else if (mem_valid) begin
      if (prev_pend && (mem_addr != prev_addr)) unstable_cnt <= unstable_cnt + 1;
      if (mem_ready) begin
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_data.push_back(mem_we ? mem_wdata : mem_rdata);
        if (mem_we) begin
          bmem[mem_addr[7:0]]    <= mem_wdata;
          wr_mask[mem_addr[7:0]] <= 1'b1;
        end
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
    prev_addr <= mem_addr;
    prev_pend <= mem_valid && !mem_ready && rst_n;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One CPU request; returns load data and cycles from request to ack
  task automatic access(input logic we, input logic [29:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc);
    cyc = 0;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    #1;
    while (!cpu_ack && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk_eq("ack_seen", 32'(cpu_ack), 32'd1);
    rd = cpu_rdata;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  // Compare one logged transfer when it exists
  task automatic chk_xfer(input string tag, input int pos, input logic we,
                          input logic [29:0] a, input logic [31:0] d);
    if (log_addr.size() > pos) begin
      chk_eq({tag, "_we"}, 32'(log_we[pos]), 32'(we));
      chk_eq({tag, "_addr"}, 32'(log_addr[pos]), 32'(a));
      chk_eq({tag, "_data"}, log_data[pos], d);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          cyc;
    int          base;

    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(negedge clk);
    chk_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk_eq("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk_eq("rst_hit_count", hit_count, 32'd0);
    chk_eq("rst_miss_count", miss_count, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold load and immediate reload
    base = log_addr.size();
    access(1'b0, 30'h10, 32'h0, rd, cyc);
    chk_eq("cold_rdata", rd, 32'h110);
    chk_eq("cold_latency", 32'(cyc), 32'd5);
    chk_eq("cold_xfers", 32'(log_addr.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      chk_xfer("cold_refill", base + i, 1'b0, 30'(32'h10 + i), 32'h110 + 32'(i));
    access(1'b0, 30'h12, 32'h0, rd, cyc);
    chk_eq("reload_rdata", rd, 32'h112);
    chk_eq("reload_latency", 32'(cyc), 32'd0);

    // Store hit, fill way 1, then dirty eviction of way 0
    access(1'b1, 30'h11, 32'hDEAD_BEEF, rd, cyc);
    chk_eq("store_hit_latency", 32'(cyc), 32'd0);
    access(1'b0, 30'h50, 32'h0, rd, cyc);
    chk_eq("way1_rdata", rd, 32'h150);
    chk_eq("way1_latency", 32'(cyc), 32'd5);
    base = log_addr.size();
    access(1'b0, 30'h90, 32'h0, rd, cyc);
    chk_eq("evict_rdata", rd, 32'h190);
    chk_eq("evict_latency", 32'(cyc), 32'd9);
    chk_eq("evict_xfers", 32'(log_addr.size() - base), 32'd8);
    for (int i = 0; i < 4; i++)
      chk_xfer("writeback", base + i, 1'b1, 30'(32'h10 + i), exp_wb[i]);
    for (int i = 0; i < 4; i++)
      chk_xfer("evict_refill", base + 4 + i, 1'b0, 30'(32'h90 + i), 32'h190 + 32'(i));
    access(1'b0, 30'h50, 32'h0, rd, cyc);
    chk_eq("way1_kept_rdata", rd, 32'h150);
    chk_eq("way1_kept_latency", 32'(cyc), 32'd0);
    access(1'b0, 30'h11, 32'h0, rd, cyc);
    chk_eq("wb_roundtrip_rdata", rd, 32'hDEAD_BEEF);
    chk_eq("wb_roundtrip_latency", 32'(cyc), 32'd5);

    // Five wait states on every transfer
    wait_cfg = 5;
    base = log_addr.size();
    access(1'b0, 30'hD1, 32'h0, rd, cyc);
    chk_eq("slow_rdata", rd, 32'h1D1);
    chk_eq("slow_latency", 32'(cyc), 32'd25);
    chk_eq("slow_xfers", 32'(log_addr.size() - base), 32'd4);
    access(1'b1, 30'h22, 32'hCAFE_F00D, rd, cyc);
    chk_eq("store_miss_latency", 32'(cyc), 32'd25);
    access(1'b0, 30'h22, 32'h0, rd, cyc);
    chk_eq("store_miss_rdata", rd, 32'hCAFE_F00D);
    chk_eq("store_miss_hit", 32'(cyc), 32'd0);
    access(1'b0, 30'h23, 32'h0, rd, cyc);
    chk_eq("store_miss_neighbor", rd, 32'h123);
    chk_eq("addr_stable", 32'(unstable_cnt), 32'd0);
    wait_cfg = 0;

    // Reset during refill aborts it and leaves the way invalid
    base = log_addr.size();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h30;
    for (int k = 0; k < 50 && log_addr.size() < base + 2; k++) begin
      @(posedge clk);
      #1;
    end
    chk_eq("pre_rst_xfers", 32'(log_addr.size() - base), 32'd2);
    chk_eq("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("abort_mem_valid", 32'(mem_valid), 32'd0);
    chk_eq("abort_cpu_ack", 32'(cpu_ack), 32'd0);
    chk_eq("abort_hit_count", hit_count, 32'd0);
    chk_eq("abort_miss_count", miss_count, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = log_addr.size();
    access(1'b0, 30'h30, 32'h0, rd, cyc);
    chk_eq("remiss_latency", 32'(cyc), 32'd5);
    chk_eq("remiss_rdata", rd, 32'h130);
    chk_eq("remiss_xfers", 32'(log_addr.size() - base), 32'd4);
    access(1'b0, 30'h11, 32'h0, rd, cyc);
    chk_eq("post_rst_miss", 32'(cyc), 32'd5);

    // Statistics: two misses and three hits after a fresh reset
    do_reset();
    access(1'b0, 30'h40, 32'h0, rd, cyc);
    access(1'b0, 30'h41, 32'h0, rd, cyc);
    chk_eq("stats_hit_rdata", rd, 32'h141);
    access(1'b0, 30'h42, 32'h0, rd, cyc);
    access(1'b1, 30'h43, 32'h1234_5678, rd, cyc);
    access(1'b0, 30'h80, 32'h0, rd, cyc);
    chk_eq("stats_miss_rdata", rd, 32'h180);
    @(negedge clk);
    chk_eq("hit_count", hit_count, EXP_HITS);
    chk_eq("miss_count", miss_count, EXP_MISSES);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
